// File: rtl/tick_gen_if.sv
// Configuration port of tick_gen: valid/ready divisor write plus the registered error pulse.
interface tick_gen_if #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CNT_W    = 26
);
    localparam int unsigned CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic              cfg_valid;
    logic              cfg_ready;
    logic [CHAN_W-1:0] cfg_chan;
    logic [CNT_W-1:0]  cfg_div;
    logic              cfg_err;

    modport master (output cfg_valid, cfg_chan, cfg_div, input cfg_ready, cfg_err);
    modport slave  (input cfg_valid, cfg_chan, cfg_div, output cfg_ready, cfg_err);
endinterface

// File: rtl/tick_gen.sv
// Multi-channel clock-enable generator: per-channel tick strobe and 50% level, runtime divisors.
// Optional define TICK_GEN_PHASE_SYNC_EN adds the sync_all phase-restart input.
module tick_gen #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned CNT_W       = 26,
    parameter int unsigned DEFAULT_DIV = 2500000
) (
    input  logic                clk,
    input  logic                resn,
`ifdef TICK_GEN_PHASE_SYNC_EN
    input  logic                sync_all,
`endif
    tick_gen_if.slave           cfg,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] level
);

    logic [CNT_W-1:0]    cnt_q      [CHANNELS];
    logic [CNT_W-1:0]    cnt_d      [CHANNELS];
    logic [CNT_W-1:0]    div_q      [CHANNELS];
    logic [CNT_W-1:0]    div_d      [CHANNELS];
    logic [CNT_W-1:0]    pend_div_q [CHANNELS];
    logic [CNT_W-1:0]    pend_div_d [CHANNELS];
    logic [CHANNELS-1:0] pend_valid_q, pend_valid_d;
    logic [CHANNELS-1:0] tick_q, tick_d;
    logic [CHANNELS-1:0] level_q, level_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;

    logic                accept;
    logic                sync;
    logic [CHANNELS-1:0] wr;
    logic [CHANNELS-1:0] tc;
    logic [CHANNELS-1:0] apply;

    // Next-state for every channel; divisor changes only land at a period boundary or while idle.
    always_comb begin
        cnt_d        = cnt_q;
        div_d        = div_q;
        pend_div_d   = pend_div_q;
        pend_valid_d = pend_valid_q;
        tick_d       = '0;
        level_d      = level_q;
        ready_d      = 1'b1;
        wr           = '0;
        tc           = '0;
        apply        = '0;
        sync         = 1'b0;
`ifdef TICK_GEN_PHASE_SYNC_EN
        sync         = sync_all;
`endif
        accept = cfg.cfg_valid && ready_q;
        err_d  = accept && (32'(cfg.cfg_chan) >= CHANNELS);

        for (int unsigned i = 0; i < CHANNELS; i++) begin
            wr[i]    = accept && (32'(cfg.cfg_chan) == i);
            // div-1 is only meaningful for an enabled channel, so gate the compare on div!=0.
            tc[i]    = (div_q[i] != '0) && (cnt_q[i] == div_q[i] - CNT_W'(1));
            apply[i] = sync || (div_q[i] == '0) || tc[i];

            if (div_q[i] == '0 || tc[i] || sync) begin
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end

            if (tc[i] && !sync) begin
                tick_d[i]  = 1'b1;
                level_d[i] = ~level_q[i];
            end
            if (sync) begin
                level_d[i] = 1'b0;
            end

            // A write landing on an apply cycle bypasses the pending slot (last write wins).
            if (apply[i]) begin
                if (wr[i]) begin
                    div_d[i] = cfg.cfg_div;
                end else if (pend_valid_q[i]) begin
                    div_d[i] = pend_div_q[i];
                end
                pend_valid_d[i] = 1'b0;
            end else if (wr[i]) begin
                pend_div_d[i]   = cfg.cfg_div;
                pend_valid_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                cnt_q[i]      <= '0;
                div_q[i]      <= CNT_W'(DEFAULT_DIV);
                pend_div_q[i] <= '0;
            end
            pend_valid_q <= '0;
            tick_q       <= '0;
            level_q      <= '0;
            ready_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            div_q        <= div_d;
            pend_div_q   <= pend_div_d;
            pend_valid_q <= pend_valid_d;
            tick_q       <= tick_d;
            level_q      <= level_d;
            ready_q      <= ready_d;
            err_q        <= err_d;
        end
    end

    assign tick          = tick_q;
    assign level         = level_q;
    assign cfg.cfg_ready = ready_q;
    assign cfg.cfg_err   = err_q;

endmodule

// File: tb/tb_tick_gen.sv
// Self-checking bench for tick_gen: a countdown reference model fills a scoreboard each edge.
module tb_tick_gen;
    localparam int unsigned CH   = 5;
    localparam int unsigned CW   = 8;
    localparam int unsigned DDIV = 5;

    typedef struct packed {
        logic [CH-1:0] tick;
        logic [CH-1:0] level;
        logic          err;
        logic          ready;
    } exp_t;

    logic          clk = 1'b0;
    logic          resn = 1'b0;
    logic [CH-1:0] tick;
    logic [CH-1:0] level;
`ifdef TICK_GEN_PHASE_SYNC_EN
    logic          sync_all = 1'b0;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int edge_n   = 0;

    exp_t        sb[$];
    int unsigned m_div [CH];
    int unsigned m_rem [CH];
    int unsigned m_pd  [CH];
    bit          m_pv  [CH];
    logic [CH-1:0] m_level;
    bit          m_ready;

    tick_gen_if #(.CHANNELS(CH), .CNT_W(CW)) cfg_if ();

    tick_gen #(.CHANNELS(CH), .CNT_W(CW), .DEFAULT_DIV(DDIV)) dut (
        .clk      (clk),
        .resn     (resn),
`ifdef TICK_GEN_PHASE_SYNC_EN
        .sync_all (sync_all),
`endif
        .cfg      (cfg_if),
        .tick     (tick),
        .level    (level)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_div[i] = DDIV;
            m_rem[i] = DDIV;
            m_pd[i]  = 0;
            m_pv[i]  = 1'b0;
        end
        m_level = '0;
        m_ready = 1'b0;
        edge_n  = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at edge %0d: observed=%h expected=%h", tag, edge_n, obs, exp);
        end
    endtask

    // One clock edge: model predicts, scoreboard stores, DUT sampled 1 time unit later.
    task automatic cycle();
        exp_t        e;
        exp_t        got;
        bit          acc;
        bit          s;
        bit          wr;
        int unsigned nd;
        @(posedge clk);
        edge_n++;
        s = 1'b0;
`ifdef TICK_GEN_PHASE_SYNC_EN
        s = sync_all;
`endif
        acc     = cfg_if.cfg_valid && m_ready;
        e.err   = acc && (32'(cfg_if.cfg_chan) >= CH);
        e.tick  = '0;
        for (int i = 0; i < CH; i++) begin
            wr = acc && (32'(cfg_if.cfg_chan) == 32'(i));
            nd = wr ? 32'(cfg_if.cfg_div) : (m_pv[i] ? m_pd[i] : m_div[i]);
            if (s) begin
                m_div[i] = nd; m_pv[i] = 1'b0; m_rem[i] = nd; m_level[i] = 1'b0;
            end else if (m_div[i] == 0) begin
                m_div[i] = nd; m_pv[i] = 1'b0; m_rem[i] = nd;
            end else begin
                m_rem[i]--;
                if (m_rem[i] == 0) begin
                    e.tick[i]  = 1'b1;
                    m_level[i] = ~m_level[i];
                    m_div[i] = nd; m_pv[i] = 1'b0; m_rem[i] = nd;
                end else if (wr) begin
                    m_pd[i] = 32'(cfg_if.cfg_div); m_pv[i] = 1'b1;
                end
            end
        end
        e.level = m_level;
        e.ready = 1'b1;
        m_ready = 1'b1;
        sb.push_back(e);
        #1;
        got.tick = tick; got.level = level; got.err = cfg_if.cfg_err; got.ready = cfg_if.cfg_ready;
        e = sb.pop_front();
        chk("tick",      32'(got.tick),  32'(e.tick));
        chk("level",     32'(got.level), 32'(e.level));
        chk("cfg_err",   32'(got.err),   32'(e.err));
        chk("cfg_ready", 32'(got.ready), 32'(e.ready));
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic cfg_write(input int unsigned ch, input int unsigned dv);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_chan  = 3'(ch);
        cfg_if.cfg_div   = CW'(dv);
        cycle();
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tick"},  32'(tick),             32'(0));
        chk({tag, "_level"}, 32'(level),            32'(0));
        chk({tag, "_err"},   32'(cfg_if.cfg_err),   32'(0));
        chk({tag, "_ready"}, 32'(cfg_if.cfg_ready), 32'(0));
    endtask

    initial begin
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_chan  = '0;
        cfg_if.cfg_div   = '0;
        model_reset();
        #12;
        chk_reset_outputs("rst");
        #1 resn = 1'b1;

        run(2);
        cfg_write(2, 3);          // mid-period rate change on channel 2
        run(3);
        cfg_write(1, 7);          // overwritten before it can apply
        cycle();
        cfg_write(1, 2);
        run(4);
        cfg_write(4, 1);          // tick every cycle
        cfg_write(0, 0);          // disable after the final tick
        run(6);
        cfg_write(5, 9);          // out of range
        cycle();
        cfg_write(7, 3);          // out of range
        run(4);
        cfg_write(0, 4);          // re-enable: first tick 4 cycles after accept
        run(6);
        while ((edge_n + 1) % 5 != 0) cycle();
        cfg_write(3, 6);          // accept coincides with terminal count
        run(14);

        // Reset in the middle of a period: outputs clear without waiting for a clock edge.
        #3 resn = 1'b0;
        #1 chk_reset_outputs("midrst");
        model_reset();
        #2 resn = 1'b1;
        run(12);

`ifdef TICK_GEN_PHASE_SYNC_EN
        cfg_write(0, 4);
        run(2);
        cfg_write(1, 4);
        run(5);
        sync_all = 1'b1;
        cfg_write(2, 4);          // applied immediately alongside the sync
        sync_all = 1'b0;
        run(10);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/tick_gen.md
Name: tick_gen

Overview:
Parametrised multi-channel clock-enable generator. It is the successor to the single fixed ripple-bit slow clock. Each channel produces a one-cycle tick strobe and a 50% square-wave level, all in the fast clock domain, with no derived clocks. Divisors are runtime-programmable over a valid/ready config port. Consumers are the LED PRNG stepping, UART baud timing and GPIO wiggle rates.

Parameters:
CHANNELS, 4, number of independent channels (1..16)
CNT_W, 26, divisor and counter width in bits
DEFAULT_DIV, 2500000, divisor loaded into every channel at reset (must fit CNT_W; 0 means disabled)

Ports:
clk  in  1  fast system clock
resn  in  1  asynchronous active-low reset
cfg_valid  in  1  config request valid
cfg_ready  out  1  config request ready
cfg_chan  in  max(1,$clog2(CHANNELS))  target channel index
cfg_div  in  CNT_W  new divisor; 0 = disable channel
cfg_err  out  1  one-cycle pulse: accepted request had cfg_chan >= CHANNELS
tick  out  CHANNELS  one-cycle strobe per channel period
level  out  CHANNELS  toggles on every tick of that channel
sync_all  in  1  phase restart of all channels (present only with the optional feature)

Behaviour:
- Reset (async assert, sync release): counters=0, div=DEFAULT_DIV, pending_valid=0, tick=0, level=0, cfg_err=0, cfg_ready=0.
- cfg_ready goes 1 on the first clk edge after reset release. It then stays 1; the port never stalls.
- Per channel, state {cnt, div, pend_div, pend_valid}.
- Counting: if div != 0, cnt increments each cycle.
- Terminal count: when cnt == div-1, tick=1 registered on the following edge, cnt returns to 0 and level toggles. div=1 gives tick high every cycle and level toggling every cycle.
- Period: tick is 1 exactly one cycle in every div cycles. level period = 2*div cycles.
- Disabled (div==0): cnt held at 0, tick=0, level holds its last value.
- Accept: cfg_valid & cfg_ready. An accept for an in-range channel writes pend_div=cfg_div and pend_valid=1. A later accept before the pending value is applied overwrites it (last write wins).
- Apply rules:
  - Active channel (div!=0): pending is applied at the next terminal-count cycle. That period's tick still fires. The new divisor governs the next period, with cnt restarting at 0. This gives glitch-free rate changes with no runt level phases.
  - Disabled channel: pending is applied the cycle after accept, with cnt=0. The first tick comes new_div cycles later.
  - Write of 0 to an active channel: disables it at the next terminal count, after that final tick.
  - Accept in the same cycle as terminal count: the old tick fires and the new divisor is taken directly, as if it had been pending.
- Out-of-range cfg_chan: request is accepted, no state changes, and cfg_err pulses for exactly one cycle (registered, one cycle after accept).
- Arithmetic: cnt is CNT_W bits unsigned. Compare uses div-1 computed in CNT_W bits; it is never evaluated when div==0, so no wrap to all-ones.
- Reset mid-operation: all state returns immediately to reset values and pending writes are lost.
- Outputs are registered, with no combinational paths from inputs to outputs.

Optional Feature:
TICK_GEN_PHASE_SYNC_EN
- Defined: adds the sync_all input. On the cycle sync_all=1, every cnt=0 and every level=0. Any pend_valid is applied immediately. No tick is generated in that cycle. All channels with equal div then tick on the same cycles. sync_all has priority over terminal count and over a config accept in the same cycle; an accepted config in that cycle is applied immediately.
- Undefined: the port is absent and channels free-run from reset.

Test Plan:
- Reset, CHANNELS=4, DEFAULT_DIV=5 -> cfg_ready rises 1 cycle after resn release; each tick pulses every 5 cycles, first at cycle 5; level toggles with each tick, period 10.
- Write chan 2 div=3 at cycle 2 of a 5-period -> tick[2] still at cycle 5, then ticks at 8, 11, 14; other channels unaffected.
- Two writes to chan 1 (div=7 then div=2) within one period -> only div=2 is applied at the next terminal count; ticks every 2 cycles, every cycle of level toggles every 2.
- Write div=0 to chan 0, later div=4 -> one final tick, then tick[0]=0 and level frozen; after the div=4 write, first tick exactly 4 cycles after accept.
- cfg_chan=5 with CHANNELS=4 -> cfg_err=1 for exactly one cycle; all tick/level sequences identical to an unwritten run. Also assert resn mid-period: outputs 0 immediately, divisors back to DEFAULT_DIV.
- With TICK_GEN_PHASE_SYNC_EN, ch0 div=4, ch1 div=4 offset by 2, pulse sync_all -> ticks on both channels coincide 4 cycles after the pulse; level=0 on both at the pulse.
